// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM state codes and requester IDs.
package mem_arb_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic REQ_IC = 1'b0;
   localparam logic REQ_DC = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker: a lone requester wins outright, a tie goes to whoever did not win last.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic ic_req,
   input  logic dc_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = ic_req | dc_req;
      grant_id    = REQ_IC;
      if (ic_req && dc_req) begin
         grant_id = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
      end else if (dc_req) begin
         grant_id = REQ_DC;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory port between icache refill and dcache refill/writeback,
// one line transaction at a time, with alternating priority on ties.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 128,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_ready,
   output logic [LINE_W-1:0] ic_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_ready,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [1:0]        state_q;
   logic              owner_q;
   logic              last_grant_q;
   logic              we_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0] wdata_q;
   logic [LINE_W-1:0] rdata_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              grant_valid;
   logic              grant_id;
   logic              timeout_hit;

   mem_arb_pick u_pick (
      .ic_req      (ic_req),
      .dc_req      (dc_req),
      .last_grant  (last_grant_q),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   // Counter holds the number of WAIT cycles already spent without mem_done.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= REQ_IC;
         last_grant_q <= REQ_IC;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         cnt_q        <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_valid) begin
                  owner_q      <= grant_id;
                  last_grant_q <= grant_id;
                  if (grant_id == REQ_DC) begin
                     addr_q  <= dc_addr;
                     we_q    <= dc_we;
                     wdata_q <= dc_wdata;
                  end else begin
                     addr_q  <= ic_addr;
                     we_q    <= 1'b0;
                     wdata_q <= '0;
                  end
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_done) begin
                  if (!we_q) begin
                     rdata_q <= mem_rdata;
                  end
                  state_q <= S_RESP;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign mem_valid = (state_q == S_ISSUE);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign ic_ready  = (state_q == S_RESP) && (owner_q == REQ_IC);
   assign dc_ready  = (state_q == S_RESP) && (owner_q == REQ_DC);
   assign ic_rdata  = rdata_q;
   assign dc_rdata  = rdata_q;
   assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a latency-programmable memory responder plus one task per scenario.
module tb_mem_arbiter;

   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 128;
   localparam int TIMEOUT = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic              ic_ready;
   logic [LINE_W-1:0] ic_rdata;
   logic              dc_req;
   logic              dc_we;
   logic [ADDR_W-1:0] dc_addr;
   logic [LINE_W-1:0] dc_wdata;
   logic              dc_ready;
   logic [LINE_W-1:0] dc_rdata;
   logic              mem_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic              mem_done;
   logic [LINE_W-1:0] mem_rdata;
   logic              busy;
   logic              err;

   logic              model_done;
   logic              stray_done;
   int                mem_lat;
   logic [LINE_W-1:0] mem_resp;
   logic [ADDR_W-1:0] issue_addr [64];
   int                issue_cyc  [64];
   int                issue_n;
   int                cyc = 0;
   int                n_checks;
   int                n_fail;

   assign mem_done = model_done | stray_done;

   mem_arbiter #(
      .ADDR_W  (ADDR_W),
      .LINE_W  (LINE_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ic_req    (ic_req),
      .ic_addr   (ic_addr),
      .ic_ready  (ic_ready),
      .ic_rdata  (ic_rdata),
      .dc_req    (dc_req),
      .dc_we     (dc_we),
      .dc_addr   (dc_addr),
      .dc_wdata  (dc_wdata),
      .dc_ready  (dc_ready),
      .dc_rdata  (dc_rdata),
      .mem_valid (mem_valid),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_done  (mem_done),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory responder: logs each issue, then pulses mem_done mem_lat cycles later (never if 0).
   initial begin
      model_done = 1'b0;
      mem_rdata  = '0;
      issue_n    = 0;
      forever begin
         @(negedge clk);
         if (mem_valid) begin
            if (issue_n < 64) begin
               issue_addr[issue_n] = mem_addr;
               issue_cyc[issue_n]  = cyc;
            end
            issue_n++;
            if (mem_lat != 0) begin
               repeat (mem_lat) @(posedge clk);
               #1;
               model_done = 1'b1;
               mem_rdata  = mem_resp;
               @(posedge clk);
               #1;
               model_done = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      ic_req = 1'b0;
      dc_req = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      ic_req = 1'b0;
      dc_req = 1'b0;
      dc_we  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({busy, err, mem_valid, mem_we, ic_ready, dc_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset.ctrl: got %b want 000000", {busy, err, mem_valid, mem_we, ic_ready, dc_ready});
      end
      n_checks++;
      if ({ic_rdata, dc_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset.rdata: got ic=%h dc=%h want 0", ic_rdata, dc_rdata);
      end
      n_checks++;
      if ({mem_addr, mem_wdata} !== '0) begin
         n_fail++;
         $display("FAIL reset.mem_fields: got addr=%h wdata=%h want 0", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_ic_read();
      mem_lat  = 4;
      mem_resp = {16{8'hA5}};
      ic_addr  = 32'h100;
      ic_req   = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         step();
         n_checks++;
         if (mem_valid !== (c == 1)) begin
            n_fail++;
            $display("FAIL ic_read.mem_valid c%0d: got %b want %b", c, mem_valid, (c == 1));
         end
         n_checks++;
         if (ic_ready !== (c == 6) || dc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ic_read.ready c%0d: got ic=%b dc=%b want ic=%b dc=0", c, ic_ready, dc_ready, (c == 6));
         end
         n_checks++;
         if (busy !== (c <= 6)) begin
            n_fail++;
            $display("FAIL ic_read.busy c%0d: got %b want %b", c, busy, (c <= 6));
         end
         if (c == 1) begin
            n_checks++;
            if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
               n_fail++;
               $display("FAIL ic_read.issue: got addr=%h we=%b want addr=00000100 we=0", mem_addr, mem_we);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (ic_rdata !== {16{8'hA5}}) begin
               n_fail++;
               $display("FAIL ic_read.rdata: got %h want %h", ic_rdata, {16{8'hA5}});
            end
            ic_req = 1'b0;
         end
      end
   endtask

   task automatic test_tie();
      int ic_pulses;
      int dc_pulses;
      ic_pulses = 0;
      dc_pulses = 0;
      mem_lat   = 2;
      mem_resp  = {16{8'h11}};
      ic_addr   = 32'h300;
      dc_addr   = 32'h400;
      dc_we     = 1'b0;
      ic_req    = 1'b1;
      dc_req    = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (ic_ready) ic_pulses++;
         if (dc_ready) dc_pulses++;
         n_checks++;
         if (mem_valid !== (c == 1 || c == 6)) begin
            n_fail++;
            $display("FAIL tie.mem_valid c%0d: got %b want %b", c, mem_valid, (c == 1 || c == 6));
         end
         n_checks++;
         if (dc_ready !== (c == 4) || ic_ready !== (c == 9)) begin
            n_fail++;
            $display("FAIL tie.ready c%0d: got ic=%b dc=%b want ic=%b dc=%b", c, ic_ready, dc_ready, (c == 9), (c == 4));
         end
         if (c == 1 || c == 6) begin
            n_checks++;
            if (mem_addr !== ((c == 1) ? 32'h400 : 32'h300)) begin
               n_fail++;
               $display("FAIL tie.addr c%0d: got %h want %h", c, mem_addr, ((c == 1) ? 32'h400 : 32'h300));
            end
         end
         if (c == 4) begin
            n_checks++;
            if (dc_rdata !== {16{8'h11}}) begin
               n_fail++;
               $display("FAIL tie.dc_rdata: got %h want %h", dc_rdata, {16{8'h11}});
            end
            dc_req = 1'b0;
         end
         if (c == 9) ic_req = 1'b0;
      end
      n_checks++;
      if (ic_pulses != 1 || dc_pulses != 1) begin
         n_fail++;
         $display("FAIL tie.pulse_count: got ic=%0d dc=%0d want ic=1 dc=1", ic_pulses, dc_pulses);
      end
   endtask

   task automatic test_alternate();
      int n0;
      int ic_cnt;
      int dc_cnt;
      logic [ADDR_W-1:0] exp_addr [5];
      exp_addr[0] = 32'h1000;
      exp_addr[1] = 32'h5000;
      exp_addr[2] = 32'h1040;
      exp_addr[3] = 32'h5040;
      exp_addr[4] = 32'h1080;
      n0       = issue_n;
      ic_cnt   = 0;
      dc_cnt   = 0;
      mem_lat  = 1;
      mem_resp = {16{8'h77}};
      dc_we    = 1'b0;
      dc_addr  = 32'h1000;
      ic_addr  = 32'h5000;
      dc_req   = 1'b1;
      ic_req   = 1'b1;
      for (int c = 1; c <= 80 && (dc_cnt < 3 || ic_cnt < 2); c++) begin
         step();
         if (ic_ready) begin
            ic_cnt++;
            n_checks++;
            if (ic_rdata !== {16{8'h77}}) begin
               n_fail++;
               $display("FAIL alternate.ic_rdata #%0d: got %h want %h", ic_cnt, ic_rdata, {16{8'h77}});
            end
            ic_addr = 32'h5000 + 32'(ic_cnt) * 32'h40;
            if (ic_cnt == 2) ic_req = 1'b0;
         end
         if (dc_ready) begin
            dc_cnt++;
            dc_addr = 32'h1000 + 32'(dc_cnt) * 32'h40;
            if (dc_cnt == 3) dc_req = 1'b0;
         end
      end
      ic_req = 1'b0;
      dc_req = 1'b0;
      n_checks++;
      if (dc_cnt != 3 || ic_cnt != 2 || issue_n - n0 != 5) begin
         n_fail++;
         $display("FAIL alternate.completion: got dc=%0d ic=%0d issues=%0d want dc=3 ic=2 issues=5", dc_cnt, ic_cnt, issue_n - n0);
      end else begin
         for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (issue_addr[n0 + k] !== exp_addr[k] || issue_cyc[n0 + k] - issue_cyc[n0] != 4 * k) begin
               n_fail++;
               $display("FAIL alternate.grant%0d: got addr=%h dcyc=%0d want addr=%h dcyc=%0d", k, issue_addr[n0 + k], issue_cyc[n0 + k] - issue_cyc[n0], exp_addr[k], 4 * k);
            end
         end
      end
   endtask

   task automatic test_writeback();
      idle(2);
      mem_lat  = 2;
      mem_resp = '1;
      dc_we    = 1'b1;
      dc_addr  = 32'h2000;
      dc_wdata = {4{32'hDEADBEEF}};
      dc_req   = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         step();
         n_checks++;
         if (mem_valid !== (c == 1) || dc_ready !== (c == 4) || ic_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL writeback.ctrl c%0d: got valid=%b dc=%b ic=%b want valid=%b dc=%b ic=0", c, mem_valid, dc_ready, ic_ready, (c == 1), (c == 4));
         end
         if (c == 1) begin
            n_checks++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== {4{32'hDEADBEEF}}) begin
               n_fail++;
               $display("FAIL writeback.issue: got we=%b addr=%h wdata=%h want we=1 addr=00002000 wdata=%h", mem_we, mem_addr, mem_wdata, {4{32'hDEADBEEF}});
            end
         end
         if (c == 4) begin
            n_checks++;
            if (dc_rdata !== {16{8'h77}}) begin
               n_fail++;
               $display("FAIL writeback.rdata_kept: got %h want %h", dc_rdata, {16{8'h77}});
            end
            dc_req = 1'b0;
            dc_we  = 1'b0;
         end
      end
   endtask

   task automatic test_timeout();
      idle(2);
      mem_lat = 0;
      ic_addr = 32'h600;
      ic_req  = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         n_checks++;
         if (mem_valid !== (c == 1) || ic_ready !== (c == 11) || dc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout.ctrl c%0d: got valid=%b ic=%b dc=%b want valid=%b ic=%b dc=0", c, mem_valid, ic_ready, dc_ready, (c == 1), (c == 11));
         end
         n_checks++;
         if (err !== (c >= 11)) begin
            n_fail++;
            $display("FAIL timeout.err c%0d: got %b want %b", c, err, (c >= 11));
         end
         if (c == 11) begin
            n_checks++;
            if (ic_rdata !== {16{8'h77}}) begin
               n_fail++;
               $display("FAIL timeout.rdata_kept: got %h want %h", ic_rdata, {16{8'h77}});
            end
            ic_req = 1'b0;
         end
      end
      stray_done = 1'b1;
      step();
      stray_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++;
         if (busy !== 1'b0 || err !== 1'b1 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout.stray_done c%0d: got busy=%b err=%b ic=%b dc=%b want busy=0 err=1 ic=0 dc=0", c, busy, err, ic_ready, dc_ready);
         end
      end
   endtask

   task automatic test_reset_wait();
      idle(1);
      mem_lat = 0;
      dc_we   = 1'b0;
      dc_addr = 32'h700;
      dc_req  = 1'b1;
      step();
      step();
      step();
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_wait.in_wait: got busy=%b want 1", busy);
      end
      reset  = 1'b1;
      dc_req = 1'b0;
      step();
      reset = 1'b0;
      n_checks++;
      if ({busy, err, mem_valid, ic_ready, dc_ready} !== 5'b0 || ic_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_wait.after: got busy=%b err=%b valid=%b ic=%b dc=%b rdata=%h want all 0", busy, err, mem_valid, ic_ready, dc_ready, ic_rdata);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++;
         if (busy !== 1'b0 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait.quiet c%0d: got busy=%b ic=%b dc=%b want 0", c, busy, ic_ready, dc_ready);
         end
      end
      mem_lat  = 3;
      mem_resp = {16{8'h3C}};
      ic_addr  = 32'h800;
      ic_req   = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         n_checks++;
         if (mem_valid !== (c == 1) || ic_ready !== (c == 5) || dc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait.retry c%0d: got valid=%b ic=%b dc=%b want valid=%b ic=%b dc=0", c, mem_valid, ic_ready, dc_ready, (c == 1), (c == 5));
         end
         if (c == 1) begin
            n_checks++;
            if (mem_addr !== 32'h800) begin
               n_fail++;
               $display("FAIL reset_wait.retry_addr: got %h want 00000800", mem_addr);
            end
         end
         if (c == 5) begin
            n_checks++;
            if (ic_rdata !== {16{8'h3C}} || err !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_wait.retry_data: got rdata=%h err=%b want rdata=%h err=0", ic_rdata, err, {16{8'h3C}});
            end
            ic_req = 1'b0;
         end
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      ic_req     = 1'b0;
      ic_addr    = '0;
      dc_req     = 1'b0;
      dc_we      = 1'b0;
      dc_addr    = '0;
      dc_wdata   = '0;
      stray_done = 1'b0;
      mem_lat    = 1;
      mem_resp   = '0;
      do_reset();
      test_reset();
      test_ic_read();
      do_reset();
      test_tie();
      do_reset();
      test_alternate();
      test_writeback();
      test_timeout();
      test_reset_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
